i_mem_loader: RTL and testbench

Program loader that fills the writable instruction memory from a byte stream before the MIPS core runs. It accepts a framed byte stream (length, instruction words, checksum) over a valid/ready handshake, assembles big-endian 32-bit words, and issues one write per word at consecutive word-aligned byte addresses. These are the same addresses the fetch path decodes with `address[9:2]`. While loading, it holds the core in reset and reports done or error.

---
 rtl/i_mem_loader_if.sv | 27 ++
 rtl/i_mem_loader.sv | 159 +++++++++++++++
 tb/tb_i_mem_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i_mem_loader_if.sv
// Loader bus: byte-stream input, instruction-memory write port and load status.
//   master : stream source / system side (drives start, rx_data, rx_valid)
//   slave  : i_mem_loader (drives rx_ready, write port and status)
interface i_mem_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, error, words_loaded
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, error, words_loaded
  );
endinterface

// File: rtl/i_mem_loader.sv
// Instruction-memory program loader. Accepts a framed byte stream
// (LEN_HI, LEN_LO, 4*N data bytes, XOR checksum), assembles big-endian words and
// writes them to consecutive word-aligned byte addresses while holding the core in reset.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : loader interface (slave side) - stream handshake, write port, status
module i_mem_loader #(
  parameter int unsigned DEPTH = 256
) (
  input logic           clock,
  input logic           reset_n,
  i_mem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StCheck, StDone, StError
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;          // first three bytes of the word in flight
  logic [7:0]  csum_q, csum_d;
  logic [8:0]  words_loaded_q, words_loaded_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        rx_ready, busy, done, error, start_ok;
  logic        accept, len_bad, last_word;
  logic [15:0] len_new;
  logic [8:0]  wl_inc;

  assign accept    = bus.rx_valid && rx_ready;
  assign len_new   = {len_q[15:8], bus.rx_data};
  assign len_bad   = (len_new == 16'd0) || (len_new > 16'(DEPTH));
  assign wl_inc    = words_loaded_q + 9'd1;
  assign last_word = ({7'd0, wl_inc} == len_q);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (start_ok) state_d = StLenHi;
      StLenHi: if (accept) state_d = StLenLo;
      StLenLo: if (accept) state_d = len_bad ? StError : StData;
      StData:  if (accept && (byte_cnt_q == 2'd3) && last_word) state_d = StCheck;
      StCheck: if (accept) state_d = (bus.rx_data == csum_q) ? StDone : StError;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    start_ok = 1'b0;
    unique case (state_q)
      StIdle: start_ok = bus.start;
      StLenHi, StLenLo, StData, StCheck: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        done     = 1'b1;
        start_ok = bus.start;
      end
      StError: begin
        error    = 1'b1;
        start_ok = bus.start;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    len_d          = len_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    csum_d         = csum_q;
    words_loaded_d = words_loaded_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;

    if (start_ok) begin
      words_loaded_d = 9'd0;
      csum_d         = 8'd0;
      byte_cnt_d     = 2'd0;
    end

    if (accept) begin
      unique case (state_q)
        StLenHi: len_d[15:8] = bus.rx_data;
        StLenLo: len_d[7:0]  = bus.rx_data;
        StData: begin
          csum_d     = csum_q ^ bus.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Address uses the pre-increment count so indices run 0..DEPTH-1
            wr_data_d      = {word_q, bus.rx_data};
            wr_addr_d      = {22'd0, words_loaded_q[7:0], 2'b00};
            wr_en_d        = 1'b1;
            words_loaded_d = wl_inc;
          end else begin
            word_d = {word_q[15:0], bus.rx_data};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q          <= 16'd0;
      byte_cnt_q     <= 2'd0;
      word_q         <= 24'd0;
      csum_q         <= 8'd0;
      words_loaded_q <= 9'd0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 32'd0;
      wr_data_q      <= 32'd0;
    end else begin
      len_q          <= len_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      csum_q         <= csum_d;
      words_loaded_q <= words_loaded_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.busy         = busy;
  assign bus.cpu_hold     = busy;
  assign bus.done         = done;
  assign bus.error        = error;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_i_mem_loader.sv
// Directed self-checking bench for i_mem_loader.
module tb_i_mem_loader;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  i_mem_loader_if bus ();

  i_mem_loader #(.DEPTH(256)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Capture every write strobe mid-cycle
  always @(negedge clock) begin
    if (bus.wr_en === 1'b1) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Present one byte after `gap` idle cycles; returns 1ns after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      tick();
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", {31'd0, bus.rx_ready}, 32'd1);
    tick();
  endtask

  // Whole frame; with gaps enabled a start pulse is injected mid-frame
  task automatic send_frame(input logic [31:0] words[$], input logic [15:0] len,
                            input logic [7:0] csum, input bit gaps);
    int idx;
    idx = 0;
    send_byte(len[15:8], 0);
    send_byte(len[7:0], gaps ? 2 : 0);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] w;
        w = words[i];
        if (gaps && idx == 5) begin
          bus.rx_valid = 1'b0;
          pulse_start();
        end
        send_byte(w[31-8*k -: 8], gaps ? int'($urandom_range(0, 3)) : 0);
        idx++;
      end
    end
    send_byte(csum, gaps ? 1 : 0);
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [31:0] words[$]);
    check({tag, "_wr_count"}, wa.size(), words.size());
    if (wa.size() == words.size()) begin
      foreach (words[i]) begin
        check({tag, "_wr_addr"}, wa[i], i * 4);
        check({tag, "_wr_data"}, wd[i], words[i]);
      end
    end
  endtask

  initial begin
    logic [31:0] w1[$];
    logic [31:0] w2[$];
    logic [31:0] w3[$];
    logic [31:0] w4[$];
    logic [31:0] wbig[$];

    bus.start    = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    reset_n      = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_error", {31'd0, bus.error}, 32'd0);
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_wr_addr", bus.wr_addr, 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_words", {23'd0, bus.words_loaded}, 32'd0);
    reset_n = 1'b1;
    tick();

    // rx_valid while idle is dropped
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAB;
    repeat (2) tick();
    bus.rx_valid = 1'b0;
    check("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd0);

    // N=1: 20^08^00^05 = 2D
    w1 = {32'h20080005};
    wa.delete(); wd.delete();
    pulse_start();
    check("n1_busy_after_start", {31'd0, bus.busy}, 32'd1);
    check("n1_ready_after_start", {31'd0, bus.rx_ready}, 32'd1);
    check("n1_hold_after_start", {31'd0, bus.cpu_hold}, 32'd1);
    send_frame(w1, 16'd1, 8'h2D, 1'b0);
    check_writes("n1", w1);
    check("n1_done", {31'd0, bus.done}, 32'd1);
    check("n1_error", {31'd0, bus.error}, 32'd0);
    check("n1_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check("n1_words", {23'd0, bus.words_loaded}, 32'd1);

    // Same frame with checksum 25 is a mismatch
    wa.delete(); wd.delete();
    pulse_start();
    check("n1bad_done_cleared", {31'd0, bus.done}, 32'd0);
    send_frame(w1, 16'd1, 8'h25, 1'b0);
    check("n1bad_error", {31'd0, bus.error}, 32'd1);
    check("n1bad_wr_count", wa.size(), 32'd1);

    // N=256 back-to-back; each word's 4 identical bytes XOR to zero
    wbig.delete();
    for (int i = 0; i < 256; i++) wbig.push_back(i * 32'h01010101);
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(wbig, 16'd256, 8'h00, 1'b0);
    check_writes("n256", wbig);
    if (wa.size() > 0) check("n256_last_addr", wa[wa.size()-1], 32'h3FC);
    check("n256_done", {31'd0, bus.done}, 32'd1);
    check("n256_words", {23'd0, bus.words_loaded}, 32'd256);

    // Zero length
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    bus.rx_valid = 1'b0;
    check("len0_error", {31'd0, bus.error}, 32'd1);
    check("len0_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("len0_busy", {31'd0, bus.busy}, 32'd0);

    // Length 257
    pulse_start();
    check("len257_error_cleared", {31'd0, bus.error}, 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    bus.rx_valid = 1'b0;
    check("len257_error", {31'd0, bus.error}, 32'd1);
    check("len257_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    repeat (2) tick();
    check("badlen_wr_count", wa.size(), 32'd0);

    // N=2, correct checksum 44, sent flipped as BB
    w2 = {32'h11223344, 32'hAABBCCDD};
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(w2, 16'd2, 8'hBB, 1'b0);
    check_writes("n2bad", w2);
    check("n2bad_error", {31'd0, bus.error}, 32'd1);
    check("n2bad_done", {31'd0, bus.done}, 32'd0);
    pulse_start();
    check("n2bad_start_clears_error", {31'd0, bus.error}, 32'd0);
    check("n2bad_start_clears_words", {23'd0, bus.words_loaded}, 32'd0);

    // N=3 with gaps and a mid-frame start (already in LEN_HI)
    // csum: (01^23^45^67)^(89^AB^CD^EF)^(DE^AD^BE^EF) = 00^00^22 = 22
    w3 = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF};
    wa.delete(); wd.delete();
    send_frame(w3, 16'd3, 8'h22, 1'b1);
    check_writes("n3gap", w3);
    check("n3gap_done", {31'd0, bus.done}, 32'd1);
    check("n3gap_words", {23'd0, bus.words_loaded}, 32'd3);

    // Reset after 6 data bytes of N=4
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    w4 = {32'h01020304, 32'h05060708};
    for (int k = 0; k < 6; k++) begin
      logic [31:0] w;
      w = w4[k/4];
      send_byte(w[31-8*(k%4) -: 8], 0);
    end
    bus.rx_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check("mid_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("mid_rst_wr_addr", bus.wr_addr, 32'd0);
    check("mid_rst_wr_data", bus.wr_data, 32'd0);
    check("mid_rst_words", {23'd0, bus.words_loaded}, 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("mid_rst_wr_count", wa.size(), 32'd1);

    // Full frame after release loads from address 0
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(w2, 16'd2, 8'h44, 1'b0);
    check_writes("post_rst", w2);
    check("post_rst_done", {31'd0, bus.done}, 32'd1);
    check("post_rst_words", {23'd0, bus.words_loaded}, 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
